// File: rtl/gat_pkg.sv
// gat_pkg: shared GAT sizing derivations and the feature-readout FSM encoding,
// so gat_top and gat_feat_readout agree on BRAM depth and address width.
package gat_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} readout_state_t;
  function automatic int feat_depth(int num_subgraphs, int num_feature_out);
    return num_subgraphs * num_feature_out;
  endfunction
  function automatic int feat_addr_w(int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/gat_readout_fifo.sv
// gat_readout_fifo: synchronous FIFO with occupancy count; dout reads zero while empty.
module gat_readout_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign dout = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/gat_feat_readout.sv
// gat_feat_readout: walks the new-feature BRAM and streams each word over AXI4-Stream.
// Define FEAT_READOUT_STALL_CNT_EN to add a saturating stall_cycles debug counter.
module gat_feat_readout
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = feat_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
  parameter int NEW_FEATURE_ADDR_W = feat_addr_w(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
`ifdef FEAT_READOUT_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);
  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(NEW_FEATURE_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  readout_state_t state, state_n;
  logic [AW:0] len, len_c, rd_idx, issue_idx, beat_cnt;
  logic [AW+1:0] addr_q;
  logic [RD_LATENCY-1:0] vsr;
  logic [CW-1:0] fifo_count;
  logic accept, fire, pop, credit, drained;
  assign accept = state == IDLE && start;
  assign len_c = num_words > DEPTH_L ? DEPTH_L : num_words;
  // Count reads still in the BRAM pipeline so every one has a FIFO slot waiting.
  assign credit = $countones(vsr) + int'(fifo_count) < FIFO_DEPTH;
  // Word 0 is issued in the start cycle itself to meet the RD_LATENCY+1 first-beat target.
  assign issue_idx = state == IDLE ? '0 : rd_idx;
  assign fire = state == IDLE ? start && len_c != '0 : state == ISSUE && credit;
  assign feat_bram_addrb = fire ? {issue_idx[AW-1:0], 2'b00} : addr_q;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign drained = vsr == '0 && fifo_count == (pop ? CW'(1) : CW'(0));
  assign m_axis_tlast = m_axis_tvalid && beat_cnt == len - ONE;
  assign busy = state == ISSUE || state == DRAIN;
  assign done = state == FINISH;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = len_c == '0 || len_c == ONE ? DRAIN : ISSUE;
      ISSUE:   if (fire && rd_idx + ONE == len) state_n = DRAIN;
      DRAIN:   if (drained) state_n = FINISH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      rd_idx   <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
      vsr      <= '0;
    end else begin
      state <= state_n;
      vsr   <= (vsr << 1) | RD_LATENCY'(fire);
      if (fire) begin
        rd_idx <= issue_idx + ONE;
        addr_q <= feat_bram_addrb;
      end
      if (accept) begin
        len      <= len_c;
        beat_cnt <= '0;
      end else if (pop) beat_cnt <= beat_cnt + ONE;
    end
  gat_readout_fifo #(.WIDTH(NEW_FEATURE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vsr[RD_LATENCY-1]),
    .pop   (pop),
    .din   (feat_bram_dout),
    .dout  (m_axis_tdata),
    .count (fifo_count)
  );
  assign m_axis_tvalid = fifo_count != '0;
`ifdef FEAT_READOUT_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if (accept) stall_cycles <= '0;
    else if (m_axis_tvalid && !m_axis_tready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_gat_feat_readout.sv
// tb_gat_feat_readout: randomized self-checking bench; a latency-1 and a latency-2 instance
// share stimulus, and one of them is monitored against an array-level reference model.
module tb_gat_feat_readout;
  localparam int DEPTH = 2708 * 16;
  localparam int AW = 16;
  logic clk = 0, rst_n = 0, start = 0, tready = 0, sel = 0;
  logic [AW:0] num_words = '0;
  logic [31:0] seed = '0;
  always #5 clk = ~clk;
  logic busy_a, done_a, tvalid_a, tlast_a, busy_b, done_b, tvalid_b, tlast_b;
  logic [AW+1:0] addr_a, addr_b;
  logic [31:0] dout_a, dout_b, tdata_a, tdata_b, r1_a, r1_b, r2_b;
  logic [31:0] stall_s;
`ifdef FEAT_READOUT_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
  assign stall_s = sel ? stall_b : stall_a;
`else
  assign stall_s = '0;
`endif
  function automatic logic [31:0] word(int i);
    return (32'hA000_0000 + i) ^ seed;
  endfunction
  always @(posedge clk) begin
    r1_a <= word(int'(addr_a[AW+1:2]));
    r1_b <= word(int'(addr_b[AW+1:2]));
    r2_b <= r1_b;
  end
  assign dout_a = r1_a;
  assign dout_b = r2_b;
  gat_feat_readout u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .busy(busy_a), .done(done_a),
    .feat_bram_addrb(addr_a), .feat_bram_dout(dout_a), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
    .m_axis_tready(tready), .m_axis_tlast(tlast_a)
`ifdef FEAT_READOUT_STALL_CNT_EN
    , .stall_cycles(stall_a)
`endif
  );
  gat_feat_readout #(.RD_LATENCY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .busy(busy_b), .done(done_b),
    .feat_bram_addrb(addr_b), .feat_bram_dout(dout_b), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(tready), .m_axis_tlast(tlast_b)
`ifdef FEAT_READOUT_STALL_CNT_EN
    , .stall_cycles(stall_b)
`endif
  );
  logic v, l, busy_s, done_s;
  logic [31:0] d;
  logic [AW+1:0] a;
  assign v = sel ? tvalid_b : tvalid_a;
  assign l = sel ? tlast_b : tlast_a;
  assign d = sel ? tdata_b : tdata_a;
  assign a = sel ? addr_b : addr_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  int checks = 0, fails = 0;
  logic [31:0] got_data[$];
  int last_idx[$];
  logic [AW+1:0] addr_seq[$];
  int hs_cycle, done_cycle, done_count, busy_cycles, first_valid, stall_ref, stall_viol, max_addr_pre, max_addr, timed_out;
  logic [AW+1:0] end_addr;
  logic [31:0] end_stall;
  logic rst_v, rst_b;
  task automatic run(input int nw, input int mode, input int budget, input int restart_k, input int abort_beat);
    logic prev_stall = 0;
    logic [31:0] prev_d = '0;
    int stop = -1;
    got_data.delete(); last_idx.delete(); addr_seq.delete();
    hs_cycle = -1; done_cycle = -1; done_count = 0; busy_cycles = 0; first_valid = -1;
    stall_ref = 0; stall_viol = 0; max_addr_pre = 0; max_addr = 0; timed_out = 1;
    @(negedge clk);
    start = 1;
    num_words = (AW+1)'(nw);
    for (int k = 0; k < budget; k++) begin
      if (k == restart_k) begin
        start = 1;
        num_words = (AW+1)'(5);
      end
      tready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : mode == 2 ? (k >= 20) : 1'($urandom_range(0, 1));
      if (abort_beat >= 0 && got_data.size() == abort_beat) begin
        rst_n = 0;
        #1;
        rst_v = v;
        rst_b = busy_s;
        start = 0;
        repeat (3) begin
          @(negedge clk);
          #1;
          if (done_s) done_count++;
        end
        rst_n = 1;
        timed_out = 0;
        return;
      end
      #1;
      if (got_data.size() == 0 && int'(a) > max_addr_pre) max_addr_pre = int'(a);
      if (int'(a) > max_addr) max_addr = int'(a);
      if (addr_seq.size() == 0 || addr_seq[$] != a) addr_seq.push_back(a);
      if (v && tready) begin
        got_data.push_back(d);
        if (l) last_idx.push_back(got_data.size() - 1);
        hs_cycle = k;
      end
      if (v && !tready) stall_ref++;
      if (prev_stall && (!v || d !== prev_d)) stall_viol++;
      prev_stall = v && !tready;
      prev_d = d;
      if (v && first_valid < 0) first_valid = k;
      if (busy_s) busy_cycles++;
      if (done_s) begin
        done_count++;
        done_cycle = k;
        if (stop < 0) stop = k + 2;
      end
      if (k == stop) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
      start = 0;
    end
    start = 0;
    end_addr = a;
    end_stall = stall_s;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b || done_a || done_b) && n < 50000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50000) begin fails++; $display("FAIL idle_wait: still busy after %0d cycles, expected idle", n); end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (tvalid_a !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", tvalid_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy_a, done_a); end
    checks++; if (addr_a !== '0 || addr_b !== '0) begin fails++; $display("FAIL reset_addr: got %h/%h expected 0", addr_a, addr_b); end
    checks++; if (tdata_a !== '0 || tlast_a !== 1'b0) begin fails++; $display("FAIL reset_tdata_tlast: got %h/%b expected 0/0", tdata_a, tlast_a); end
    checks++; if (tvalid_b !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL reset_b: got tvalid %b busy %b expected 0 0", tvalid_b, busy_b); end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_basic();
    int bad = 0;
    sel = 0; seed = '0; wait_idle();
    run(16, 0, 200, -1, -1);
    checks++; if (timed_out != 0) begin fails++; $display("FAIL basic_timeout: no done within budget, expected done"); end
    checks++; if (got_data.size() != 16) begin fails++; $display("FAIL basic_count: got %0d beats expected 16", got_data.size()); end
    foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL basic_data: %0d wrong beats expected 0", bad); end
    checks++; if (last_idx.size() != 1 || last_idx[0] != 15) begin fails++; $display("FAIL basic_tlast: got %0d tlast beats expected one at 15", last_idx.size()); end
    checks++; if (done_count != 1 || done_cycle != hs_cycle + 1) begin fails++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_count, done_cycle, hs_cycle + 1); end
    checks++; if (first_valid != 2) begin fails++; $display("FAIL basic_first_valid: got cycle %0d expected 2", first_valid); end
    bad = addr_seq.size() == 16 ? 0 : 1;
    foreach (addr_seq[i]) if (int'(addr_seq[i]) != i * 4) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL basic_addr_seq: %0d address errors over %0d values expected 0x00..0x3C", bad, addr_seq.size()); end
  endtask
  task automatic test_backpressure();
    int bad = 0;
    sel = 0; seed = $urandom; wait_idle();
    run(16, 1, 300, -1, -1);
    checks++; if (got_data.size() != 16) begin fails++; $display("FAIL bp_count: got %0d beats expected 16", got_data.size()); end
    foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL bp_data: %0d wrong beats expected 0", bad); end
    checks++; if (stall_viol != 0) begin fails++; $display("FAIL bp_stable: %0d unstable stall cycles expected 0", stall_viol); end
    checks++; if (done_count != 1 || done_cycle != hs_cycle + 1) begin fails++; $display("FAIL bp_done: got %0d pulses at %0d expected 1 at %0d", done_count, done_cycle, hs_cycle + 1); end
`ifdef FEAT_READOUT_STALL_CNT_EN
    checks++; if (end_stall !== 32'(stall_ref)) begin fails++; $display("FAIL bp_stall_cycles: got %0d expected %0d", end_stall, stall_ref); end
`endif
  endtask
  task automatic test_zero();
    sel = 0; wait_idle();
    run(0, 0, 50, -1, -1);
    checks++; if (first_valid != -1 || got_data.size() != 0) begin fails++; $display("FAIL zero_tvalid: tvalid at cycle %0d expected never", first_valid); end
    checks++; if (done_count != 1 || done_cycle != 2) begin fails++; $display("FAIL zero_done: got %0d pulses at %0d expected 1 at 2", done_count, done_cycle); end
    checks++; if (busy_cycles != 1) begin fails++; $display("FAIL zero_busy: got %0d busy cycles expected 1", busy_cycles); end
  endtask
  task automatic test_lat2();
    int bad = 0;
    sel = 1; seed = $urandom; wait_idle();
    run(8, 2, 300, -1, -1);
    checks++; if (max_addr_pre > 12) begin fails++; $display("FAIL lat2_credit: highest address before first pop %0d expected <= 12", max_addr_pre); end
    checks++; if (got_data.size() != 8) begin fails++; $display("FAIL lat2_count: got %0d beats expected 8", got_data.size()); end
    foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL lat2_data: %0d wrong beats expected 0", bad); end
    checks++; if (first_valid != 3) begin fails++; $display("FAIL lat2_first_valid: got cycle %0d expected 3", first_valid); end
    checks++; if (done_count != 1 || done_cycle != hs_cycle + 1) begin fails++; $display("FAIL lat2_done: got %0d pulses at %0d expected 1 at %0d", done_count, done_cycle, hs_cycle + 1); end
  endtask
  task automatic test_start_while_busy();
    int bad = 0;
    sel = 0; seed = $urandom; wait_idle();
    run(16, 0, 200, 5, -1);
    checks++; if (got_data.size() != 16) begin fails++; $display("FAIL busy_start_count: got %0d beats expected 16", got_data.size()); end
    foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
    checks++; if (bad != 0 || last_idx.size() != 1 || last_idx[0] != 15) begin fails++; $display("FAIL busy_start_data: %0d wrong beats, %0d tlasts expected 0 and 1", bad, last_idx.size()); end
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nw = $urandom_range(1, 40);
      int bad = 0;
      sel = 1'($urandom_range(0, 1)); seed = $urandom; wait_idle();
      run(nw, 3, 600, -1, -1);
      foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
      checks++; if (got_data.size() != nw || bad != 0) begin fails++; $display("FAIL rand_data: it %0d got %0d beats %0d wrong expected %0d beats 0 wrong", it, got_data.size(), bad, nw); end
      checks++; if (last_idx.size() != 1 || last_idx[0] != nw - 1) begin fails++; $display("FAIL rand_tlast: it %0d got %0d tlasts expected one at %0d", it, last_idx.size(), nw - 1); end
      checks++; if (done_count != 1 || done_cycle != hs_cycle + 1 || stall_viol != 0) begin fails++; $display("FAIL rand_done: it %0d done %0d at %0d, unstable %0d expected 1 at %0d, 0", it, done_count, done_cycle, stall_viol, hs_cycle + 1); end
      checks++; if (first_valid != (sel ? 3 : 2)) begin fails++; $display("FAIL rand_first_valid: it %0d got %0d expected %0d", it, first_valid, sel ? 3 : 2); end
`ifdef FEAT_READOUT_STALL_CNT_EN
      checks++; if (end_stall !== 32'(stall_ref)) begin fails++; $display("FAIL rand_stall_cycles: got %0d expected %0d", end_stall, stall_ref); end
`endif
    end
  endtask
  task automatic test_abort();
    int bad = 0;
    sel = 0; seed = $urandom; wait_idle();
    run(16, 0, 200, -1, 5);
    checks++; if (rst_v !== 1'b0 || rst_b !== 1'b0) begin fails++; $display("FAIL abort_outputs: got tvalid %b busy %b expected 0 0", rst_v, rst_b); end
    checks++; if (done_count != 0) begin fails++; $display("FAIL abort_done: got %0d pulses expected 0", done_count); end
    seed = $urandom; wait_idle();
    run(16, 0, 200, -1, -1);
    foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
    checks++; if (got_data.size() != 16 || bad != 0) begin fails++; $display("FAIL abort_restart: got %0d beats %0d wrong expected 16 from word 0", got_data.size(), bad); end
  endtask
  task automatic test_clamp();
    int bad = 0;
    sel = 0; seed = $urandom; wait_idle();
    run(DEPTH + 5, 0, DEPTH + 200, -1, -1);
    checks++; if (got_data.size() != DEPTH) begin fails++; $display("FAIL clamp_count: got %0d beats expected %0d", got_data.size(), DEPTH); end
    foreach (got_data[i]) if (got_data[i] !== word(i)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL clamp_data: %0d wrong beats expected 0", bad); end
    checks++; if (int'(end_addr) != (DEPTH - 1) * 4 || max_addr != (DEPTH - 1) * 4) begin fails++; $display("FAIL clamp_addr: final %h max %h expected %h", end_addr, max_addr, (DEPTH - 1) * 4); end
    checks++; if (last_idx.size() != 1 || last_idx[0] != DEPTH - 1) begin fails++; $display("FAIL clamp_tlast: got %0d tlasts expected one at %0d", last_idx.size(), DEPTH - 1); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_lat2();
    test_start_while_busy();
    test_random();
    test_abort();
    test_clamp();
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
